// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALUOp codes (also consumed by the ALU-control decoder) and mux selects.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

endpackage

// File: rtl/mips_mc_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready and counts retired instructions.
module mips_mc_main_control
  import mips_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [3:0]       state_dbg,
  output logic [CNT_W-1:0] instr_count
);

  state_t state;
  state_t next_state;
  logic   retire;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Reset wins over a retirement landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)       instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

  always_comb begin
    next_state = S_FETCH;
    retire     = 1'b0;
    case (state)
      S_FETCH:     next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDI_EX;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  next_state = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next_state = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: begin
        next_state = mem_ready ? S_FETCH : S_MEM_WRITE;
        retire     = mem_ready;
      end
      S_EXECUTE:   next_state = S_ALU_WB;
      S_ADDI_EX:   next_state = S_ADDI_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      default:     next_state = S_FETCH;
    endcase
  end

  // Everything is held low during reset so an abandoned instruction writes nothing.
  always_comb begin
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PCSRC_ALU;
    illegal_op  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = SRCB_IMM_SH;
          illegal_op = !op_supported(opcode);
        end
        S_MEM_ADDR, S_ADDI_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_ALU_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_SUB;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        S_ADDI_WB: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mips_mc_main_control.sv
// Self-checking bench for mips_mc_main_control: directed scenarios plus a randomized
// instruction stream checked against a path-per-instruction reference model.
module tb_mips_mc_main_control;

  typedef int path_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = 6'b0;
  logic        mem_ready = 1'b0;
  logic [1:0]  ALUOp;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
  logic        PCWrite, PCWriteCond;
  logic [1:0]  PCSource;
  logic        illegal_op;
  logic [3:0]  state_dbg;
  logic [31:0] instr_count;
  logic [15:0] ctrl;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_count = '0;

  mips_mc_main_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSource(PCSource), .illegal_op(illegal_op), .state_dbg(state_dbg),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign ctrl = {ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
                 MemtoReg, RegDst, RegWrite, PCWrite, PCWriteCond, PCSource};

  // Field order: ALUOp_SrcA_SrcB_IorD_MRd_MWr_IRW_M2R_RDst_RegW_PCW_PCWC_PCSrc
  function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
    case (st)
      0:  return 16'b00_0_01_0_1_0_0_0_0_0_0_0_00 | (mr ? 16'h0088 : 16'h0000);
      1:  return 16'b00_0_11_0_0_0_0_0_0_0_0_0_00;
      2:  return 16'b00_1_10_0_0_0_0_0_0_0_0_0_00;
      3:  return 16'b00_0_00_1_1_0_0_0_0_0_0_0_00;
      4:  return 16'b00_0_00_0_0_0_0_1_0_1_0_0_00;
      5:  return 16'b00_0_00_1_0_1_0_0_0_0_0_0_00;
      6:  return 16'b10_1_00_0_0_0_0_0_0_0_0_0_00;
      7:  return 16'b00_0_00_0_0_0_0_0_1_1_0_0_00;
      8:  return 16'b01_1_00_0_0_0_0_0_0_0_0_1_01;
      9:  return 16'b00_0_00_0_0_0_0_0_0_0_1_0_10;
      10: return 16'b00_1_10_0_0_0_0_0_0_0_0_0_00;
      11: return 16'b00_0_00_0_0_0_0_0_0_1_0_0_00;
      default: return 16'h0000;
    endcase
  endfunction

  // The state walk an instruction takes with no memory stalls.
  function automatic path_t path_of(input logic [5:0] op);
    case (op)
      6'b100011: return '{0, 1, 2, 3, 4};
      6'b101011: return '{0, 1, 2, 5};
      6'b000000: return '{0, 1, 6, 7};
      6'b001000: return '{0, 1, 10, 11};
      6'b000100: return '{0, 1, 8};
      6'b000010: return '{0, 1, 9};
      default:   return '{0, 1};
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctrl !== 16'h0 || illegal_op !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_outputs cycle %0d: got ctrl=%h ill=%b, expected 0000/0", i, ctrl, illegal_op);
      end
      checks++;
      if (state_dbg !== 4'd0) begin
        failures++;
        $display("[TB] FAIL reset_state cycle %0d: got %0d, expected 0", i, state_dbg);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd0 || MemRead !== 1'b1 || IRWrite !== 1'b1 || PCWrite !== 1'b1 ||
        ALUOp !== 2'b00 || ALUSrcB !== 2'b01) begin
      failures++;
      $display("[TB] FAIL post_reset_fetch: got st=%0d ctrl=%h, expected st=0 ctrl=%h",
               state_dbg, ctrl, exp_ctrl(0, 1'b1));
    end
    checks++;
    if (instr_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL post_reset_count: got %0d, expected 0", instr_count);
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
    exp_count = '0;
  endtask

  task automatic test_lw();
    int seq[5] = '{0, 1, 2, 3, 4};
    opcode = 6'b100011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (state_dbg !== 4'(seq[i])) begin
        failures++;
        $display("[TB] FAIL lw_state cycle %0d: got %0d, expected %0d", i, state_dbg, seq[i]);
      end
      checks++;
      if (RegWrite !== 1'(seq[i] == 4) || MemtoReg !== 1'(seq[i] == 4)) begin
        failures++;
        $display("[TB] FAIL lw_writeback cycle %0d: got RegWrite=%b MemtoReg=%b, expected %b", i, RegWrite, MemtoReg, 1'(seq[i] == 4));
      end
      @(posedge clk); #1;
    end
    exp_count++;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd0 || instr_count !== exp_count || IRWrite !== 1'b0 || MemRead !== 1'b1) begin
      failures++;
      $display("[TB] FAIL lw_retire: got st=%0d cnt=%0d IRWrite=%b MemRead=%b, expected st=0 cnt=%0d IRWrite=0 MemRead=1",
               state_dbg, instr_count, IRWrite, MemRead, exp_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    int seq[4] = '{0, 1, 6, 7};
    opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (state_dbg !== 4'(seq[i])) begin
        failures++;
        $display("[TB] FAIL rtype_state cycle %0d: got %0d, expected %0d", i, state_dbg, seq[i]);
      end
      checks++;
      if (ALUOp !== ((seq[i] == 6) ? 2'b10 : 2'b00)) begin
        failures++;
        $display("[TB] FAIL rtype_aluop cycle %0d: got %b, expected %b", i, ALUOp, (seq[i] == 6) ? 2'b10 : 2'b00);
      end
      checks++;
      if ({RegWrite, RegDst} !== ((seq[i] == 7) ? 2'b11 : 2'b00)) begin
        failures++;
        $display("[TB] FAIL rtype_regwrite cycle %0d: got %b, expected %b", i, {RegWrite, RegDst}, (seq[i] == 7) ? 2'b11 : 2'b00);
      end
      @(posedge clk); #1;
    end
    exp_count++;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd0 || instr_count !== exp_count) begin
      failures++;
      $display("[TB] FAIL rtype_retire: got st=%0d cnt=%0d, expected st=0 cnt=%0d", state_dbg, instr_count, exp_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sw_stall();
    int   seq[6] = '{0, 1, 2, 5, 5, 5};
    logic mr[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    opcode = 6'b101011;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i];
      @(negedge clk);
      checks++;
      if (state_dbg !== 4'(seq[i])) begin
        failures++;
        $display("[TB] FAIL sw_state cycle %0d: got %0d, expected %0d", i, state_dbg, seq[i]);
      end
      checks++;
      if (MemWrite !== 1'(seq[i] == 5) || instr_count !== exp_count) begin
        failures++;
        $display("[TB] FAIL sw_memwrite cycle %0d: got MemWrite=%b cnt=%0d, expected %b cnt=%0d",
                 i, MemWrite, instr_count, 1'(seq[i] == 5), exp_count);
      end
      @(posedge clk); #1;
    end
    exp_count++;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd0 || instr_count !== exp_count || MemWrite !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sw_retire: got st=%0d cnt=%0d MemWrite=%b, expected st=0 cnt=%0d MemWrite=0",
               state_dbg, instr_count, MemWrite, exp_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_beq_illegal();
    int seq[3] = '{0, 1, 8};
    opcode = 6'b000100; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state_dbg !== 4'(seq[i])) begin
        failures++;
        $display("[TB] FAIL beq_state cycle %0d: got %0d, expected %0d", i, state_dbg, seq[i]);
      end
      @(posedge clk); #1;
    end
    exp_count++;
    checks++;
    if (1'b1) begin end
    opcode = 6'b111111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (instr_count !== exp_count) begin
          failures++;
          $display("[TB] FAIL beq_retire_count: got %0d, expected %0d", instr_count, exp_count);
        end
      end
      checks++;
      if (state_dbg !== 4'(i) || illegal_op !== 1'(i == 1)) begin
        failures++;
        $display("[TB] FAIL illegal_decode cycle %0d: got st=%0d ill=%b, expected st=%0d ill=%b",
                 i, state_dbg, illegal_op, i, 1'(i == 1));
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd0 || instr_count !== exp_count || illegal_op !== 1'b0) begin
      failures++;
      $display("[TB] FAIL illegal_return: got st=%0d cnt=%0d ill=%b, expected st=0 cnt=%0d ill=0",
               state_dbg, instr_count, illegal_op, exp_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_branch_outputs();
    opcode = 6'b000100; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd8 || ALUOp !== 2'b01 || PCWriteCond !== 1'b1 || PCSource !== 2'b01) begin
      failures++;
      $display("[TB] FAIL beq_outputs: got st=%0d ALUOp=%b PCWC=%b PCSrc=%b, expected 8/01/1/01",
               state_dbg, ALUOp, PCWriteCond, PCSource);
    end
    @(posedge clk); #1;
    exp_count++;
    mem_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    opcode = 6'b100011; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd3 || ctrl !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: got st=%0d ctrl=%h, expected st=3 ctrl=0000", state_dbg, ctrl);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_count = '0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd0 || instr_count !== 32'd0 || RegWrite !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_abandon: got st=%0d cnt=%0d RegWrite=%b, expected 0/0/0",
               state_dbg, instr_count, RegWrite);
    end
    // Reset landing on a retiring cycle must leave the count at zero.
    opcode = 6'b000000; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd0 || instr_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_priority: got st=%0d cnt=%0d, expected st=0 cnt=0", state_dbg, instr_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [5:0] legal_ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    for (int n = 0; n < 120; n++) begin
      logic [5:0] op;
      path_t      p;
      int         pos;
      op  = ($urandom_range(0, 7) < 6) ? legal_ops[$urandom_range(0, 5)] : 6'($urandom);
      p   = path_of(op);
      pos = 0;
      opcode = op;
      while (pos < p.size()) begin
        int   st;
        logic mr;
        st = p[pos];
        mr = ($urandom_range(0, 3) != 0);
        mem_ready = mr;
        @(negedge clk);
        checks++;
        if (state_dbg !== 4'(st) || ctrl !== exp_ctrl(st, mr)) begin
          failures++;
          $display("[TB] FAIL rand_ctrl instr %0d op=%b: got st=%0d ctrl=%h, expected st=%0d ctrl=%h",
                   n, op, state_dbg, ctrl, st, exp_ctrl(st, mr));
        end
        checks++;
        if (illegal_op !== 1'(st == 1 && p.size() == 2) || instr_count !== exp_count) begin
          failures++;
          $display("[TB] FAIL rand_status instr %0d op=%b: got ill=%b cnt=%0d, expected ill=%b cnt=%0d",
                   n, op, illegal_op, instr_count, 1'(st == 1 && p.size() == 2), exp_count);
        end
        if (!((st == 0 || st == 3 || st == 5) && !mr)) pos++;
        @(posedge clk); #1;
      end
      if (p.size() > 2) exp_count++;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 4'd0 || instr_count !== exp_count) begin
      failures++;
      $display("[TB] FAIL rand_final: got st=%0d cnt=%0d, expected st=0 cnt=%0d", state_dbg, instr_count, exp_count);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_sw_stall();
    test_branch_outputs();
    test_beq_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
